// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 instruction-fetch slice.
package mips32_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

  // FETCH: request outstanding; IDLE: buffer full, no request;
  // DISCARD: request outstanding whose response belongs to a flushed stream.
  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_IDLE    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  // Fetch addresses are word addresses; the low two bits are forced to zero.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mips32_fetch_buffer.sv
// Two-entry {pc, instruction} FIFO between the fetch FSM and the datapath.
// flush wins over push and pop; a push while full is ignored.
module mips32_fetch_buffer
  import mips32_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [31:0]        push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  output logic [31:0]        head_pc,
  output logic [INSTR_W-1:0] head_instr,
  output logic [1:0]         count,
  output logic               empty,
  output logic               full
);

  logic [31:0]        pc_mem    [2];
  logic [INSTR_W-1:0] instr_mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer and occupancy update; flush empties the buffer in one edge.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Entry storage; contents only matter while counted as occupied.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

  // Head view reads zero when nothing is buffered.
  always_comb begin
    head_pc    = '0;
    head_instr = '0;
    if (!empty) begin
      head_pc    = pc_mem[rd_ptr];
      head_instr = instr_mem[rd_ptr];
    end
  end

endmodule

// File: rtl/mips32_fetch.sv
// Instruction-fetch front end: issues word fetches to instruction memory,
// buffers up to two instructions and handles redirects, including the
// case where a memory response is still owed for a flushed stream.
//
// Handshakes: imem_req/imem_ack -- imem_addr is held while imem_req=1 until
// imem_ack is sampled high, rdata valid with ack. instr_valid/instr_ready --
// an instruction transfers on any edge where both are 1; instr_valid never
// depends on instr_ready.
module mips32_fetch
  import mips32_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic [31:0]        instr_pc,
  output fetch_state_e       state_dbg,
  output logic [1:0]         count_dbg
);

  localparam logic [1:0] FULL_COUNT = 2'(BUF_DEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_addr_q, fetch_addr_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  new_pc;
  logic         push;
  logic         pop;
  logic         buf_empty;
  logic         buf_full;
  logic [1:0]   count;
  logic [1:0]   count_after;

  assign new_pc      = word_align(redirect_pc);
  assign pop         = instr_valid & instr_ready;
  assign push        = (state_q == ST_FETCH) & imem_ack & ~redirect & ~buf_full;
  assign count_after = count + {1'b0, push} - {1'b0, pop};

  assign imem_req    = (state_q != ST_IDLE);
  assign imem_addr   = fetch_addr_q;
  assign instr_valid = ~buf_empty;
  assign state_dbg   = state_q;
  assign count_dbg   = count;

  mips32_fetch_buffer u_buffer (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (redirect),
    .push_pc    (fetch_addr_q),
    .push_instr (imem_rdata),
    .head_pc    (instr_pc),
    .head_instr (instruction),
    .count      (count),
    .empty      (buf_empty),
    .full       (buf_full)
  );

  // State and address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      fetch_addr_q <= PC_RESET;
      pc_q         <= PC_RESET;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      pc_q         <= pc_d;
    end
  end

  // Next-state and address selection; redirect takes priority everywhere.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    pc_d         = pc_q;
    case (state_q)
      ST_FETCH: begin
        if (redirect) begin
          pc_d = new_pc;
          if (imem_ack) begin
            fetch_addr_d = new_pc;
          end else begin
            // Response still owed for the old address; drop it later.
            state_d = ST_DISCARD;
          end
        end else if (imem_ack) begin
          pc_d         = pc_q + 32'd4;
          fetch_addr_d = fetch_addr_q + 32'd4;
          state_d      = (count_after < FULL_COUNT) ? ST_FETCH : ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (redirect) begin
          pc_d         = new_pc;
          fetch_addr_d = new_pc;
          state_d      = ST_FETCH;
        end else if (pop) begin
          fetch_addr_d = pc_q;
          state_d      = ST_FETCH;
        end
      end
      ST_DISCARD: begin
        if (redirect) begin
          pc_d = new_pc;
          if (imem_ack) begin
            fetch_addr_d = new_pc;
            state_d      = ST_FETCH;
          end
        end else if (imem_ack) begin
          fetch_addr_d = pc_q;
          state_d      = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips32_fetch.sv
// Bench for mips32_fetch: main instance at the default reset PC plus a
// second instance whose reset PC sits just below the 32-bit wrap point.
module tb_mips32_fetch;
  import mips32_pkg::*;

  localparam logic [31:0] K = 32'hA5A5_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // main instance
  logic         imem_req, ack_on, redirect, instr_valid, instr_ready;
  logic [31:0]  imem_addr, imem_rdata, redirect_pc, instruction, instr_pc;
  fetch_state_e st;
  logic [1:0]   cnt;
  assign imem_rdata = ack_on ? (imem_addr ^ K) : 32'h0;

  mips32_fetch dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(ack_on), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc), .state_dbg(st), .count_dbg(cnt)
  );

  // wrap-around instance
  logic         w_req, w_ack, w_redirect, w_valid, w_ready;
  logic [31:0]  w_addr, w_rdata, w_redirect_pc, w_instr, w_pc;
  fetch_state_e w_st;
  logic [1:0]   w_cnt;
  assign w_rdata = w_ack ? (w_addr ^ K) : 32'h0;

  mips32_fetch #(.PC_RESET(32'hFFFF_FFF8), .BUF_DEPTH(2)) u_wrap (
    .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .redirect(w_redirect),
    .redirect_pc(w_redirect_pc), .instr_valid(w_valid), .instr_ready(w_ready),
    .instruction(w_instr), .instr_pc(w_pc), .state_dbg(w_st), .count_dbg(w_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1; ack_on = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    w_ack = 1'b0; w_ready = 1'b0; w_redirect = 1'b0; w_redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL reset_req: got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_cmp++; if (instruction !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 00000000", instruction); end
    n_cmp++; if (instr_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 00000000", instr_pc); end
    n_cmp++; if (st !== ST_FETCH) begin n_err++; $display("FAIL reset_state: got %0d want %0d", st, ST_FETCH); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    ack_on = 1'b1; instr_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (instr_valid && exp_q.size() > 0) begin
        exp_pc = exp_q.pop_front();
        n_cmp++; if (instr_pc !== exp_pc) begin n_err++; $display("FAIL stream_pc: got %h want %h", instr_pc, exp_pc); end
        n_cmp++; if (instruction !== (exp_pc ^ K)) begin n_err++; $display("FAIL stream_instr: got %h want %h", instruction, exp_pc ^ K); end
      end else begin
        n_cmp++; n_err++; $display("FAIL stream_valid: got %b want 1 (cycle %0d)", instr_valid, c);
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stream_left: got %0d want 0", exp_q.size()); end
    ack_on = 1'b0; instr_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    ack_on = 1'b1; instr_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (st !== ST_IDLE) begin n_err++; $display("FAIL bp_state: got %0d want %0d", st, ST_IDLE); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL bp_req: got %b want 0", imem_req); end
    n_cmp++; if (cnt !== 2'd2) begin n_err++; $display("FAIL bp_count: got %0d want 2", cnt); end
    instr_ready = 1'b1;
    // Head is popped on the coming edge.
    exp_pc = exp_q.pop_front();
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc) begin n_err++; $display("FAIL bp_head: got %b/%h want 1/%h", instr_valid, instr_pc, exp_pc); end
    @(posedge clk); #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_err++; $display("FAIL bp_refetch: got %b/%h want 1/00000008", imem_req, imem_addr); end
    for (int c = 0; c < 6 && exp_q.size() > 0; c++) begin
      if (instr_valid) begin
        exp_pc = exp_q.pop_front();
        n_cmp++; if (instr_pc !== exp_pc || instruction !== (exp_pc ^ K)) begin n_err++; $display("FAIL bp_data: got %h/%h want %h/%h", instr_pc, instruction, exp_pc, exp_pc ^ K); end
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_timeout: got %0d left want 0", exp_q.size()); end
    ack_on = 1'b0; instr_ready = 1'b0;
  endtask

  task automatic test_redirect_idle();
    do_reset();
    ack_on = 1'b1; instr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ack_on = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0043;
    @(posedge clk); #1;
    redirect = 1'b0;
    n_cmp++; if (st !== ST_FETCH) begin n_err++; $display("FAIL ridle_state: got %0d want %0d", st, ST_FETCH); end
    n_cmp++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL ridle_addr: got %h want 00000040", imem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL ridle_valid: got %b want 0", instr_valid); end
  endtask

  task automatic test_redirect_discard();
    do_reset();
    ack_on = 1'b0; instr_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      redirect = 1'b0;
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL disc_hold: got %b/%h want 1/00000000", imem_req, imem_addr); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL disc_valid: got %b want 0", instr_valid); end
    end
    n_cmp++; if (st !== ST_DISCARD) begin n_err++; $display("FAIL disc_state: got %0d want %0d", st, ST_DISCARD); end
    ack_on = 1'b1;
    @(posedge clk); #1;
    ack_on = 1'b0;
    n_cmp++; if (imem_addr !== 32'h100) begin n_err++; $display("FAIL disc_newaddr: got %h want 00000100", imem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL disc_dropped: got %b want 0", instr_valid); end
    exp_q.push_back(32'h100);
    ack_on = 1'b1;
    @(posedge clk); #1;
    ack_on = 1'b0;
    exp_pc = exp_q.pop_front();
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instruction !== (exp_pc ^ K)) begin n_err++; $display("FAIL disc_first: got %b/%h/%h want 1/%h/%h", instr_valid, instr_pc, instruction, exp_pc, exp_pc ^ K); end
    instr_ready = 1'b0;
  endtask

  task automatic test_redirect_ack_pop();
    do_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    ack_on = 1'b1; instr_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      exp_pc = exp_q.pop_front();
      n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc) begin n_err++; $display("FAIL rap_old: got %b/%h want 1/%h", instr_valid, instr_pc, exp_pc); end
    end
    // ack, pop and redirect all land on the next edge
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    @(posedge clk); #1;
    redirect = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rap_valid: got %b want 0", instr_valid); end
    n_cmp++; if (cnt !== 2'd0) begin n_err++; $display("FAIL rap_count: got %0d want 0", cnt); end
    n_cmp++; if (imem_addr !== 32'h200) begin n_err++; $display("FAIL rap_addr: got %h want 00000200", imem_addr); end
    exp_q.push_back(32'h200); exp_q.push_back(32'h204);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      exp_pc = exp_q.pop_front();
      n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instruction !== (exp_pc ^ K)) begin n_err++; $display("FAIL rap_new: got %b/%h/%h want 1/%h/%h", instr_valid, instr_pc, instruction, exp_pc, exp_pc ^ K); end
    end
    ack_on = 1'b0; instr_ready = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    n_cmp++; if (w_addr !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL wrap_reset: got %h want fffffff8", w_addr); end
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000); exp_q.push_back(32'h0000_0004);
    w_ack = 1'b1; w_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      exp_pc = exp_q.pop_front();
      n_cmp++; if (w_valid !== 1'b1 || w_pc !== exp_pc || w_instr !== (exp_pc ^ K)) begin n_err++; $display("FAIL wrap_seq: got %b/%h/%h want 1/%h/%h", w_valid, w_pc, w_instr, exp_pc, exp_pc ^ K); end
    end
    w_ack = 1'b0; w_ready = 1'b0;
  endtask

  task automatic test_reset_in_discard();
    do_reset();
    ack_on = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0300;
    @(posedge clk); #1;
    redirect = 1'b0;
    n_cmp++; if (st !== ST_DISCARD) begin n_err++; $display("FAIL rd_pre: got %0d want %0d", st, ST_DISCARD); end
    reset = 1'b1; redirect = 1'b1; ack_on = 1'b1; instr_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; redirect = 1'b0; ack_on = 1'b0; instr_ready = 1'b0;
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rd_addr: got %h want 00000000", imem_addr); end
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rd_req: got %b want 1", imem_req); end
    n_cmp++; if (cnt !== 2'd0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL rd_count: got %0d/%b want 0/0", cnt, instr_valid); end
    n_cmp++; if (st !== ST_FETCH) begin n_err++; $display("FAIL rd_state: got %0d want %0d", st, ST_FETCH); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_idle();
    test_redirect_discard();
    test_redirect_ack_pop();
    test_wrap();
    test_reset_in_discard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips32_fetch.md
MIPS32_FETCH -- requirements
Module: mips32_fetch

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2: instruction buffer entries; only the value 2 is supported.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  instruction-memory request.
REQ-006 imem_addr  output  32  word address of the outstanding request.
REQ-007 imem_ack  input  1  memory completion; imem_rdata is valid in the same cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 redirect  input  1  flush and restart fetch at redirect_pc.
REQ-010 redirect_pc  input  32  new fetch address; bits [1:0] are ignored and treated as 0.
REQ-011 instr_valid  output  1  instruction and instr_pc are valid.
REQ-012 instr_ready  input  1  downstream datapath accepts the instruction.
REQ-013 instruction  output  32  instruction word; drives the datapath's instruction_set input.
REQ-014 instr_pc  output  32  address of the presented instruction.

Function
REQ-015 The block SHALL implement three states: FETCH (imem_req=1), IDLE (imem_req=0, buffer full) and DISCARD (imem_req=1, response dropped).
REQ-016 The block SHALL keep two address registers: fetch_addr, which drives imem_addr, and pc, the next sequential address.
REQ-017 imem_addr SHALL remain stable while imem_req=1 until imem_ack is sampled high.
REQ-018 In FETCH, imem_ack=1 with redirect=0 SHALL push {fetch_addr, imem_rdata} into the buffer and advance fetch_addr and pc by 4, with 32-bit wrap: 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-019 After a push, the block SHALL stay in FETCH if the next-cycle count is below 2; otherwise it SHALL enter IDLE.
REQ-020 IDLE SHALL return to FETCH in the cycle after a pop; fetch_addr SHALL then equal pc.
REQ-021 instr_valid SHALL equal (count != 0); instruction and instr_pc SHALL show the buffer head.
REQ-022 A pop SHALL occur when instr_valid and instr_ready are both 1; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-023 When the buffer is empty, instruction and instr_pc SHALL read 0.
REQ-024 With single-cycle ack and ready held at 1, throughput SHALL be one instruction per cycle, with latency ack-edge to instr_valid of one cycle.
REQ-025 redirect SHALL take priority over push and pop, and SHALL empty the buffer on the same edge.
REQ-026 On that redirect edge, pc SHALL load {redirect_pc[31:2], 2'b00}.
REQ-027 Redirect in FETCH without ack SHALL move the block to DISCARD with fetch_addr held.
REQ-028 Redirect in FETCH with ack SHALL drop the data and re-enter FETCH, with fetch_addr set to the new pc.
REQ-029 Redirect in IDLE SHALL enter FETCH at the new pc.
REQ-030 In DISCARD, imem_ack SHALL drop the data and enter FETCH with fetch_addr set to pc.
REQ-031 A second redirect in DISCARD SHALL only reload pc.
REQ-032 The block SHALL never push while count == 2.

Reset
REQ-033 On a clock edge with reset=1, the block SHALL set: state FETCH, pc and fetch_addr to PC_RESET, count 0.
REQ-034 After reset, imem_req SHALL read 1, instr_valid 0, instruction 0 and instr_pc 0.
REQ-035 Reset SHALL override redirect, ack and ready.
REQ-036 Reset mid-request SHALL abandon the outstanding access; the memory model SHALL tolerate a dropped request.

Structure
REQ-037 Shared package mips32_pkg SHALL hold INSTR_W=32, the state encoding and the default PC_RESET.
REQ-038 The 2-entry {pc, instr} FIFO SHALL be a sub-module, mips32_fetch_buffer, with push, pop, flush, count, head, empty and full.

Verification
REQ-039 Reset release, imem_ack=1 always, rdata=addr^32'hA5A5_0000, ready=1 -> instr_pc sequence 0,4,8,... on consecutive cycles, instruction matches.
REQ-040 ready=0 for 5 cycles -> buffer holds PCs 0 and 4, state IDLE, imem_req=0; ready=1 -> PC 8 requested one cycle after the first pop.
REQ-041 ack delayed 3 cycles, redirect=1 (redirect_pc=32'h0000_0103) in cycle 1 -> imem_addr held until ack, data dropped, next request at 32'h0000_0100, instr_valid=0 meanwhile.
REQ-042 redirect coincident with ack and a pop -> buffer empty next cycle, no instruction from the old stream ever presented.
REQ-043 PC_RESET=32'hFFFF_FFF8 -> instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-044 reset asserted during DISCARD -> next cycle imem_addr=PC_RESET, imem_req=1, count=0.
